// File: rtl/dunc16_sequencer_if.sv
// Control bundle between the dunc16 sequencer and its datapath.
// The sequencer drives the master side; the datapath (or bench) drives the slave side.
interface dunc16_sequencer_if;
  logic [3:0]  IR_OP;
  logic        AN;
  logic        AZ;
  logic        MEM_READY;

  logic [3:0]  T;
  logic        FETCH;
  logic        EXECUTE;
  logic        EN_MA;
  logic        EN_MD;
  logic        EN_IR;
  logic        EN_PC;
  logic        EN_AC;
  logic        EN_LINK;
  logic        INCR_PC;
  logic        SEL_MA;
  logic        SEL_PC;
  logic        MEM_RD;
  logic        MEM_WE;
  logic        DO_LDA;
  logic        DO_ADD;
  logic        HALTED;
  logic [15:0] INSTR_COUNT;

  modport master (
    input  IR_OP, AN, AZ, MEM_READY,
    output T, FETCH, EXECUTE, EN_MA, EN_MD, EN_IR, EN_PC, EN_AC, EN_LINK,
           INCR_PC, SEL_MA, SEL_PC, MEM_RD, MEM_WE, DO_LDA, DO_ADD,
           HALTED, INSTR_COUNT
  );

  modport slave (
    output IR_OP, AN, AZ, MEM_READY,
    input  T, FETCH, EXECUTE, EN_MA, EN_MD, EN_IR, EN_PC, EN_AC, EN_LINK,
           INCR_PC, SEL_MA, SEL_PC, MEM_RD, MEM_WE, DO_LDA, DO_ADD,
           HALTED, INSTR_COUNT
  );
endinterface

// File: rtl/dunc16_sequencer.sv
// Four-phase FETCH/EXECUTE timing and control decode for the dunc16 accumulator CPU,
// with memory wait-state stretching, HALT and a retired-instruction counter.
module dunc16_sequencer (
  input  logic                CLK,
  input  logic                RESET,
  dunc16_sequencer_if.master  bus
);

  typedef enum logic [1:0] {PH_T0, PH_T1, PH_T2, PH_T3} phase_t;

  typedef enum logic [3:0] {
    OP_LDA  = 4'd0,
    OP_STA  = 4'd1,
    OP_ADD  = 4'd2,
    OP_JMP  = 4'd3,
    OP_BAN  = 4'd4,
    OP_BL   = 4'd5,
    OP_RET  = 4'd6,
    OP_HALT = 4'd15
  } opcode_t;

  logic        run_q,    run_d;
  logic        fetch_q,  fetch_d;
  phase_t      phase_q,  phase_d;
  logic        halted_q, halted_d;
  logic [15:0] count_q,  count_d;

  logic        active;
  logic        mem_rd, mem_we;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      run_q    <= 1'b0;
      fetch_q  <= 1'b1;
      phase_q  <= PH_T0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      run_q    <= run_d;
      fetch_q  <= fetch_d;
      phase_q  <= phase_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  // Control decode: pure function of registered state plus IR_OP/AN.
  always_comb begin
    active       = run_q & ~halted_q;
    mem_rd       = 1'b0;
    mem_we       = 1'b0;
    bus.EN_MA    = 1'b0;
    bus.EN_MD    = 1'b0;
    bus.EN_IR    = 1'b0;
    bus.EN_PC    = 1'b0;
    bus.EN_AC    = 1'b0;
    bus.EN_LINK  = 1'b0;
    bus.INCR_PC  = 1'b0;
    bus.SEL_MA   = 1'b0;
    bus.SEL_PC   = 1'b0;
    bus.DO_LDA   = 1'b0;
    bus.DO_ADD   = 1'b0;

    if (active) begin
      unique case (phase_q)
        PH_T0: begin
          if (fetch_q) begin
            bus.EN_MA = 1'b1;
          end else if (bus.IR_OP == OP_LDA || bus.IR_OP == OP_ADD || bus.IR_OP == OP_STA) begin
            bus.EN_MA  = 1'b1;
            bus.SEL_MA = 1'b1;
          end
        end
        PH_T1: begin
          if (fetch_q || bus.IR_OP == OP_LDA || bus.IR_OP == OP_ADD) begin
            mem_rd    = 1'b1;
            bus.EN_MD = 1'b1;
          end else if (bus.IR_OP == OP_STA) begin
            mem_we = 1'b1;
          end else if (bus.IR_OP == OP_BL) begin
            bus.EN_LINK = 1'b1;
          end
        end
        PH_T2: begin
          if (fetch_q) begin
            bus.EN_IR   = 1'b1;
            bus.INCR_PC = 1'b1;
          end else begin
            case (bus.IR_OP)
              OP_LDA: begin bus.EN_AC = 1'b1; bus.DO_LDA = 1'b1; end
              OP_ADD: begin bus.EN_AC = 1'b1; bus.DO_ADD = 1'b1; end
              OP_JMP,
              OP_BL:  bus.EN_PC = 1'b1;
              OP_BAN: bus.EN_PC = bus.AN;
              OP_RET: begin bus.EN_PC = 1'b1; bus.SEL_PC = 1'b1; end
              default: ;
            endcase
          end
        end
        PH_T3: ;
        default: ;
      endcase
    end

    bus.MEM_RD      = mem_rd;
    bus.MEM_WE      = mem_we;
    bus.T           = 4'b0001 << phase_q;
    bus.FETCH       = fetch_q;
    bus.EXECUTE     = ~fetch_q;
    bus.HALTED      = halted_q;
    bus.INSTR_COUNT = count_q;
  end

  // Next state: first edge out of reset only arms RUN; memory T1 holds until MEM_READY.
  always_comb begin
    run_d    = run_q;
    fetch_d  = fetch_q;
    phase_d  = phase_q;
    halted_d = halted_q;
    count_d  = count_q;

    if (!run_q) begin
      run_d = 1'b1;
    end else if (!halted_q) begin
      if (!(phase_q == PH_T1 && (mem_rd || mem_we) && !bus.MEM_READY))
        phase_d = phase_t'(phase_q + 2'd1);
      if (phase_q == PH_T3) begin
        fetch_d = ~fetch_q;
        if (!fetch_q) begin
          count_d = count_q + 16'd1;
          if (bus.IR_OP == OP_HALT)
            halted_d = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dunc16_sequencer.sv
// Directed bench for dunc16_sequencer: walks each instruction phase by phase
// against hand-derived control words, plus wait states, HALT, async reset and counter wrap.
module tb_dunc16_sequencer;

  logic CLK;
  logic RESET;

  dunc16_sequencer_if bus ();

  dunc16_sequencer dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Control word: {EN_MA,EN_MD,EN_IR,EN_PC,EN_AC,EN_LINK,INCR_PC,SEL_MA,SEL_PC,MEM_RD,MEM_WE,DO_LDA,DO_ADD}
  logic [12:0] ctrl;
  assign ctrl = {bus.EN_MA, bus.EN_MD, bus.EN_IR, bus.EN_PC, bus.EN_AC, bus.EN_LINK,
                 bus.INCR_PC, bus.SEL_MA, bus.SEL_PC, bus.MEM_RD, bus.MEM_WE,
                 bus.DO_LDA, bus.DO_ADD};

  localparam logic [12:0] C_NONE = 13'h0000;
  localparam logic [12:0] C_F0   = 13'h1000;  // EN_MA
  localparam logic [12:0] C_RD   = 13'h0808;  // EN_MD, MEM_RD
  localparam logic [12:0] C_F2   = 13'h0440;  // EN_IR, INCR_PC
  localparam logic [12:0] C_MAIR = 13'h1020;  // EN_MA, SEL_MA
  localparam logic [12:0] C_LDA  = 13'h0102;  // EN_AC, DO_LDA
  localparam logic [12:0] C_ADD  = 13'h0101;  // EN_AC, DO_ADD
  localparam logic [12:0] C_WE   = 13'h0004;  // MEM_WE
  localparam logic [12:0] C_PC   = 13'h0200;  // EN_PC, SEL_PC=0
  localparam logic [12:0] C_LINK = 13'h0080;  // EN_LINK
  localparam logic [12:0] C_RET  = 13'h0210;  // EN_PC, SEL_PC=1

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc(input string tag, input logic f, input int ph, input logic [12:0] exp);
    logic [3:0] t_exp;
    t_exp = 4'b0001 << ph;
    check({tag, "_T"},     32'(bus.T),     32'(t_exp));
    check({tag, "_FETCH"}, 32'(bus.FETCH), 32'(f));
    check({tag, "_ctrl"},  32'(ctrl),      32'(exp));
    step();
  endtask

  // One complete instruction starting at FETCH T0; waits = held EXECUTE T1 cycles.
  // MEM_READY is low in every non-memory phase to show it is ignored there.
  task automatic instr(input string tag, input logic [3:0] op,
                       input logic [12:0] e0, input logic [12:0] e1, input logic [12:0] e2,
                       input int waits, input logic [15:0] cnt_after);
    logic mem;
    mem = (op == 4'd0) || (op == 4'd1) || (op == 4'd2);
    bus.IR_OP = op;
    bus.MEM_READY = 1'b0;  cyc({tag, "_F0"}, 1'b1, 0, C_F0);
    bus.MEM_READY = 1'b1;  cyc({tag, "_F1"}, 1'b1, 1, C_RD);
    bus.MEM_READY = 1'b0;  cyc({tag, "_F2"}, 1'b1, 2, C_F2);
                           cyc({tag, "_F3"}, 1'b1, 3, C_NONE);
                           cyc({tag, "_E0"}, 1'b0, 0, e0);
    for (int w = 0; w < waits; w++)
      cyc($sformatf("%s_E1w%0d", tag, w), 1'b0, 1, e1);
    bus.MEM_READY = mem;   cyc({tag, "_E1"}, 1'b0, 1, e1);
    bus.MEM_READY = 1'b0;  cyc({tag, "_E2"}, 1'b0, 2, e2);
                           cyc({tag, "_E3"}, 1'b0, 3, C_NONE);
    check({tag, "_count"}, 32'(bus.INSTR_COUNT), 32'(cnt_after));
  endtask

  initial begin
    RESET = 1'b0;
    bus.IR_OP = 4'd0;
    bus.AN = 1'b0;
    bus.AZ = 1'b0;
    bus.MEM_READY = 1'b1;

    repeat (4) step();
    check("rst_T",       32'(bus.T),           32'h1);
    check("rst_FETCH",   32'(bus.FETCH),       32'h1);
    check("rst_EXECUTE", 32'(bus.EXECUTE),     32'h0);
    check("rst_ctrl",    32'(ctrl),            32'h0);
    check("rst_count",   32'(bus.INSTR_COUNT), 32'h0);
    check("rst_halted",  32'(bus.HALTED),      32'h0);

    RESET = 1'b1;
    #1;
    check("prerun_ctrl", 32'(ctrl), 32'h0);
    step();

    instr("lda",  4'd0,  C_MAIR, C_RD,   C_LDA,  0, 16'd1);
    instr("add",  4'd2,  C_MAIR, C_RD,   C_ADD,  0, 16'd2);
    instr("sta",  4'd1,  C_MAIR, C_WE,   C_NONE, 3, 16'd3);
    instr("jmp",  4'd3,  C_NONE, C_NONE, C_PC,   0, 16'd4);
    bus.AN = 1'b1;
    instr("ban1", 4'd4,  C_NONE, C_NONE, C_PC,   0, 16'd5);
    bus.AN = 1'b0;
    instr("ban0", 4'd4,  C_NONE, C_NONE, C_NONE, 0, 16'd6);
    instr("bl",   4'd5,  C_NONE, C_LINK, C_PC,   0, 16'd7);
    instr("ret",  4'd6,  C_NONE, C_NONE, C_RET,  0, 16'd8);
    instr("nop",  4'd9,  C_NONE, C_NONE, C_NONE, 0, 16'd9);
    instr("halt", 4'd15, C_NONE, C_NONE, C_NONE, 0, 16'd10);

    bus.MEM_READY = 1'b1;
    check("halt_flag", 32'(bus.HALTED), 32'h1);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halt%0d_ctrl", i),  32'(ctrl),            32'h0);
      check($sformatf("halt%0d_T", i),     32'(bus.T),           32'h1);
      check($sformatf("halt%0d_count", i), 32'(bus.INSTR_COUNT), 32'd10);
      step();
    end
    check("halt_stays", 32'(bus.HALTED), 32'h1);

    // Reset released: run again, then assert RESET in the middle of FETCH T2.
    RESET = 1'b0;
    #1;
    check("rst2_halted", 32'(bus.HALTED), 32'h0);
    step();
    RESET = 1'b1;
    step();
    bus.IR_OP = 4'd0;
    cyc("r2_F0", 1'b1, 0, C_F0);
    cyc("r2_F1", 1'b1, 1, C_RD);
    check("r2_F2_ctrl", 32'(ctrl), 32'(C_F2));
    #2;
    RESET = 1'b0;
    #1;
    check("midrst_T",     32'(bus.T),           32'h1);
    check("midrst_FETCH", 32'(bus.FETCH),       32'h1);
    check("midrst_ctrl",  32'(ctrl),            32'h0);
    check("midrst_count", 32'(bus.INSTR_COUNT), 32'h0);

    // Counter wrap: preload the counter near the top instead of retiring 65534 NOPs.
    step();
    RESET = 1'b1;
    step();
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    instr("wrap1", 4'd7, C_NONE, C_NONE, C_NONE, 0, 16'hFFFF);
    instr("wrap2", 4'd7, C_NONE, C_NONE, C_NONE, 0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
